// File: rtl/score_digit_ctrl_if.sv
// Load/write handshake bundle between the score source and the digit controller.
// The master drives value/load; the slave reports progress and digit strobes.
interface score_digit_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
);
  logic [BIN_WIDTH-1:0]  value;
  logic                  load;
  logic                  busy;
  logic                  done;
  logic [3:0]            number;
  logic [NUM_DIGITS-1:0] write_sel;

  modport master (
    output value, load,
    input  busy, done, number, write_sel
  );

  modport slave (
    input  value, load,
    output busy, done, number, write_sel
  );
endinterface

// File: rtl/score_digit_ctrl.sv
// Score overlay digit controller: iterative binary-to-BCD conversion,
// per-digit write strobes and shared glyph ROM arbitration.
module score_digit_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int WIDTH      = 25,
  parameter int HEIGHT     = 52,
  parameter int ROM_AW     = 14
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  score_digit_ctrl_if.slave        bus,
  input  logic [NUM_DIGITS-1:0]    overlap_vec,
  input  logic [11*NUM_DIGITS-1:0] image_addr_vec,
  input  logic [4*NUM_DIGITS-1:0]  out_num_vec,
  output logic [ROM_AW-1:0]        rom_addr,
  output logic                     pix_valid
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CW    = $clog2(BIN_WIDTH + 1);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned GLYPH = WIDTH * HEIGHT;
  localparam int unsigned MAXV  = 10 ** NUM_DIGITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  state_t                state, state_n;
  logic [BIN_WIDTH-1:0]  bin_q, bin_n;
  logic [BCD_W-1:0]      bcd_q, bcd_n, adj;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [IW-1:0]         widx_q, widx_n;
  logic                  sat_q, sat_n;
  logic [3:0]            num_q, num_n;
  logic [NUM_DIGITS-1:0] wsel_q, wsel_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin_q;
    bcd_n   = bcd_q;
    cnt_n   = cnt_q;
    widx_n  = widx_q;
    sat_n   = sat_q;
    num_n   = num_q;
    wsel_n  = '0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          state_n = SHIFT;
          bin_n   = bus.value;
          bcd_n   = '0;
          cnt_n   = CW'(BIN_WIDTH);
          sat_n   = 32'(bus.value) > MAXV;
        end
      end
      SHIFT: begin
        bcd_n = {adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_n = bin_q << 1;
        cnt_n = cnt_q - CW'(1);
        // Last shift: the first digit strobe leaves on this same edge
        if (cnt_q == CW'(1)) begin
          state_n = WRITE;
          widx_n  = '0;
          wsel_n  = NUM_DIGITS'(1);
          num_n   = sat_q ? 4'd9 : bcd_n[3:0];
        end
      end
      WRITE: begin
        if (widx_q == IW'(NUM_DIGITS - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          widx_n = widx_q + IW'(1);
          wsel_n = NUM_DIGITS'(1) << widx_n;
          num_n  = sat_q ? 4'd9 : bcd_q[{widx_n, 2'b00} +: 4];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      widx_q <= '0;
      sat_q  <= 1'b0;
      num_q  <= '0;
      wsel_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      bin_q  <= bin_n;
      bcd_q  <= bcd_n;
      cnt_q  <= cnt_n;
      widx_q <= widx_n;
      sat_q  <= sat_n;
      num_q  <= num_n;
      wsel_q <= wsel_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.number    = num_q;
  assign bus.write_sel = wsel_q;

  logic              hit;
  logic [ROM_AW-1:0] sel_addr;

  // Scan high to low so the lowest overlapping sprite wins
  always_comb begin
    hit      = 1'b0;
    sel_addr = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (overlap_vec[i]) begin
        hit      = 1'b1;
        sel_addr = ROM_AW'(32'(out_num_vec[4*i +: 4]) * GLYPH
                   + 32'(image_addr_vec[11*i +: 11]));
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (hit)
        rom_addr <= sel_addr;
      pix_valid <= hit;
    end
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Bench for score_digit_ctrl: queued expectations for digit writes and
// ROM arbitration, checked by independent monitors.
module tb_score_digit_ctrl;

  logic        pixel_clk;
  logic        reset_n;
  logic [3:0]  overlap_vec;
  logic [43:0] image_addr_vec;
  logic [15:0] out_num_vec;
  logic [13:0] rom_addr;
  logic        pix_valid;

  score_digit_ctrl_if #(.NUM_DIGITS(4), .BIN_WIDTH(14)) bus ();

  score_digit_ctrl #(
    .NUM_DIGITS(4), .BIN_WIDTH(14), .WIDTH(25), .HEIGHT(52), .ROM_AW(14)
  ) dut (
    .pixel_clk      (pixel_clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .overlap_vec    (overlap_vec),
    .image_addr_vec (image_addr_vec),
    .out_num_vec    (out_num_vec),
    .rom_addr       (rom_addr),
    .pix_valid      (pix_valid)
  );

  typedef struct {
    logic [3:0] sel;
    logic [3:0] num;
    logic       dn;
  } wr_t;

  typedef struct {
    int          due;
    logic        pv;
    logic [13:0] addr;
  } arb_t;

  wr_t  wr_q[$];
  arb_t arb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Write/done monitor
  always @(negedge pixel_clk) begin
    if (reset_n && (bus.write_sel != 4'd0 || bus.done)) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: sel=%b num=%0d done=%b",
                 bus.write_sel, bus.number, bus.done);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (bus.write_sel != e.sel || bus.number != e.num
            || bus.done != e.dn) begin
          errors++;
          $display("FAIL write: got sel=%b num=%0d done=%b expected sel=%b num=%0d done=%b",
                   bus.write_sel, bus.number, bus.done, e.sel, e.num, e.dn);
        end
      end
    end
  end

  // Arbitration monitor
  always @(negedge pixel_clk) begin
    while (arb_q.size() != 0 && arb_q[0].due <= cyc) begin
      arb_t a;
      a = arb_q.pop_front();
      checks++;
      if (pix_valid != a.pv || rom_addr != a.addr) begin
        errors++;
        $display("FAIL arb: got pv=%b addr=%0d expected pv=%b addr=%0d",
                 pix_valid, rom_addr, a.pv, a.addr);
      end
    end
  end

  task automatic do_load(input logic [13:0] v, input logic [15:0] exp_bcd,
                         input bit inject);
    for (int j = 0; j < 4; j++)
      wr_q.push_back('{sel: 4'(1 << j), num: exp_bcd[4*j +: 4], dn: 1'b0});
    wr_q.push_back('{sel: 4'd0, num: exp_bcd[15:12], dn: 1'b1});
    bus.value = v;
    bus.load  = 1'b1;
    @(posedge pixel_clk);
    #1 bus.load = 1'b0;
    chk("busy_after_load", int'(bus.busy), 1);
    for (int c = 1; c < 18; c++) begin
      if (inject && c == 3) begin
        bus.value = 14'd42;
        bus.load  = 1'b1;
      end
      @(posedge pixel_clk);
      #1 bus.load = 1'b0;
    end
    @(posedge pixel_clk);
    #1;
    chk("done_at_k18", int'(bus.done), 1);
    chk("busy_at_k18", int'(bus.busy), 1);
    @(posedge pixel_clk);
    #1;
    chk("done_at_k19", int'(bus.done), 0);
    chk("busy_at_k19", int'(bus.busy), 0);
  endtask

  task automatic arb(input logic [3:0] ov, input logic [43:0] ia,
                     input logic [15:0] on, input logic pv,
                     input logic [13:0] addr);
    overlap_vec    = ov;
    image_addr_vec = ia;
    out_num_vec    = on;
    arb_q.push_back('{due: cyc + 1, pv: pv, addr: addr});
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.value      = '0;
    bus.load       = 1'b0;
    overlap_vec    = '0;
    image_addr_vec = '0;
    out_num_vec    = '0;
    repeat (2) @(posedge pixel_clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_number", int'(bus.number), 0);
    chk("rst_write_sel", int'(bus.write_sel), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    reset_n = 1'b1;
    @(posedge pixel_clk);
    #1;

    do_load(14'd1234, 16'h1234, 1'b0);
    do_load(14'd0, 16'h0000, 1'b0);
    do_load(14'd9999, 16'h9999, 1'b0);
    do_load(14'd16383, 16'h9999, 1'b0);
    do_load(14'd1234, 16'h1234, 1'b1);
    do_load(14'd5078, 16'h5078, 1'b0);

    // Abort mid-conversion; no digit writes may follow
    bus.value = 14'd1234;
    bus.load  = 1'b1;
    @(posedge pixel_clk);
    #1 bus.load = 1'b0;
    repeat (5) @(posedge pixel_clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_write_sel", int'(bus.write_sel), 0);
    chk("abort_number", int'(bus.number), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (3) @(posedge pixel_clk);
    #1 reset_n = 1'b1;
    repeat (25) @(posedge pixel_clk);
    #1;
    chk("abort_busy_late", int'(bus.busy), 0);

    arb(4'b0110, {11'd0, 11'd5, 11'd10, 11'd0},
        {4'd0, 4'd3, 4'd7, 4'd0}, 1'b1, 14'd9110);
    arb(4'b0000, '0, '0, 1'b0, 14'd9110);
    arb(4'b1000, {11'd1299, 11'd0, 11'd0, 11'd0},
        {4'd9, 4'd0, 4'd0, 4'd0}, 1'b1, 14'd12999);
    arb(4'b0001, '0, '0, 1'b1, 14'd0);
    arb(4'b1111, {11'd1, 11'd2, 11'd3, 11'd100},
        {4'd5, 4'd6, 4'd7, 4'd2}, 1'b1, 14'd2700);
    arb(4'b0001, {11'd0, 11'd0, 11'd0, 11'd2047},
        {4'd0, 4'd0, 4'd0, 4'd15}, 1'b1, 14'd5163);
    arb(4'b0000, '0, '0, 1'b0, 14'd5163);
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("arb_queue_drained", arb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
